sr_reg_bank: RTL
================

SR_REG_BANK -- requirements
Module: sr_reg_bank

Interface
REQ-001 Parameter WIDTH, default 4, number of independent SR channels (1..32).
REQ-002 Parameter MODE, default 0, resolution of S=R=1: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
REQ-003 Parameter CNT_W, default 4, width of the saturating conflict counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  update enable; when 0, q is held and the per-cycle flags read 0.
REQ-007 s  input  WIDTH  per-channel set request.
REQ-008 r  input  WIDTH  per-channel reset request.
REQ-009 clr_cnt  input  1  synchronous clear of conflict_cnt.
REQ-010 q  output  WIDTH  registered channel state.
REQ-011 qb  output  WIDTH  complement of q, always exactly ~q; both outputs are never low together.
REQ-012 conflict  output  WIDTH  registered; bit i =1 when channel i sampled s=r=1 with en=1.
REQ-013 race  output  WIDTH  registered; bit i =1 when channel i sampled 11 in the previous enabled cycle and 00 in the current one.
REQ-014 conflict_cnt  output  CNT_W  number of enabled cycles in which any conflict bit was set, saturating.

Function
REQ-015 Per channel, when en=1: sr=00 -> q holds; 10 -> q=1; 01 -> q=0; 11 -> resolved per MODE.
REQ-016 MODE 0 holds q on 11; MODE 1 sets q=1; MODE 2 sets q=0; MODE 3 sets q=~q.
REQ-017 Latency: q, qb, conflict and race reflect inputs sampled at edge N in the cycle following edge N (1-cycle registered, no combinational path from s/r to any output).
REQ-018 Channels are independent; a conflict on one channel does not affect the q of another.
REQ-019 An internal per-channel register holds "last enabled sample was 11"; it updates only when en=1, so en=0 cycles between 11 and 00 still produce race.
REQ-020 race for a channel is asserted for exactly one cycle per 11->00 transition; 11->10, 11->01 and 11->11 do not assert race.
REQ-021 conflict_cnt increments by 1 on each enabled edge at which |(s&r) is 1, regardless of how many channels conflict.
REQ-022 conflict_cnt saturates at 2^CNT_W-1 and does not wrap.
REQ-023 When clr_cnt=1, conflict_cnt becomes 0 on that edge and the conflict in the same cycle is not counted (clear wins).
REQ-024 When en=0: q, conflict_cnt and the last-11 registers hold; conflict=0 and race=0; clr_cnt remains effective.

Reset
REQ-025 When rst=1 at a rising edge: q=0, qb=all ones, conflict=0, race=0, conflict_cnt=0, last-11 registers=0.
REQ-026 rst has priority over en, clr_cnt and all s/r inputs.
REQ-027 Reset mid-sequence (e.g. while the previous sample was 11) suppresses any race on the first post-reset cycle.

Verification (WIDTH=4, CNT_W=4, en=1 unless stated)
REQ-028 MODE 0, channel 0 driven through sr=00,10,11,01,11,00, one cycle each, after reset -> q[0]=0,1,1,0,0,0 and qb[0] its complement; conflict[0] high after the 11 steps; race[0] high only after the final 00; conflict_cnt=2.
REQ-029 The same sequence repeated for MODE 1, 2 and 3 -> q[0] after the two 11 steps is 1/1 (MODE 1), 0/0 (MODE 2), and 0/1 (MODE 3, toggling from 1 and then from 0).
REQ-030 s=4'b1111, r=4'b1111 held 20 cycles -> conflict=4'b1111 each cycle; conflict_cnt rises by 1 per cycle and stops at 15; clr_cnt pulse during the 11 -> conflict_cnt=0 on the next cycle.
REQ-031 Channel 2: sr=11, then en=0 for 3 cycles with sr=10, then en=1 with sr=00 -> q[2] unchanged during en=0; race[2]=1 for one cycle only.
REQ-032 rst asserted one cycle after sr=11 on all channels, then sr=00 -> q=0, qb=4'b1111, race=0, conflict_cnt=0.
REQ-033 Random s/r/en/clr_cnt for 10k cycles, all MODEs -> qb==~q on every cycle, and q, conflict, race and conflict_cnt match the cycle-accurate reference model.

Source files
------------

// File: rtl/sr_reg_bank.sv
// Bank of independent SR flip-flop channels with a parameterisable S=R=1
// resolution, per-channel conflict/race flags and a saturating conflict counter.
module sr_reg_bank #(
    parameter int WIDTH = 4,
    parameter int MODE  = 0,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] conflict,
    output logic [WIDTH-1:0] race,
    output logic [CNT_W-1:0] conflict_cnt
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] last11;
    logic [WIDTH-1:0] conflict_r;
    logic [WIDTH-1:0] race_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] both;

    assign both = s & r;

    // Per-channel next state from the sampled set/reset pair
    always_comb begin
        q_next = q_r;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            case ({s[i], r[i]})
                2'b10:   q_next[i] = 1'b1;
                2'b01:   q_next[i] = 1'b0;
                2'b11: begin
                    case (MODE)
                        1:       q_next[i] = 1'b1;
                        2:       q_next[i] = 1'b0;
                        3:       q_next[i] = ~q_r[i];
                        default: q_next[i] = q_r[i];
                    endcase
                end
                default: q_next[i] = q_r[i];
            endcase
        end
    end

    // Channel state, flags and last-11 history; history only advances on enabled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r        <= '0;
            last11     <= '0;
            conflict_r <= '0;
            race_r     <= '0;
        end else if (en) begin
            q_r        <= q_next;
            last11     <= both;
            conflict_r <= both;
            race_r     <= last11 & ~s & ~r;
        end else begin
            conflict_r <= '0;
            race_r     <= '0;
        end
    end

    // Saturating conflict counter; clear wins over a same-cycle conflict
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_r <= '0;
        end else if (en && (|both) && (cnt_r != '1)) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign q            = q_r;
    assign qb           = ~q_r;
    assign conflict     = conflict_r;
    assign race         = race_r;
    assign conflict_cnt = cnt_r;

endmodule
